xor_cipher_rx: RTL and testbench
================================

XOR_CIPHER_RX -- requirements
Module: xor_cipher_rx

Interface
REQ-001 SHALL have parameter SEED_DEFAULT, default 16'hACE1: LFSR value substituted when an all-zero seed is loaded.
REQ-002 SHALL have parameter SYNC_WORD, default 8'hA5: plaintext byte that marks frame alignment.
REQ-003 SHALL have parameter FRAME_LEN, default 16: payload bytes between sync words (used only when XOR_RX_RESYNC_EN is defined).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 key_load  input  1  load key_seed into LFSR on this cycle.
REQ-007 key_seed  input  16  keystream seed.
REQ-008 ct_bit  input  1  serial ciphertext bit.
REQ-009 ct_valid  input  1  ct_bit qualifier, one bit per asserted cycle.
REQ-010 pt_bit  output  1  decrypted bit.
REQ-011 pt_valid  output  1  pt_bit qualifier.
REQ-012 byte_out  output  8  assembled plaintext byte, MSB first.
REQ-013 byte_valid  output  1  one-cycle strobe for byte_out.
REQ-014 locked  output  1  high while aligned to SYNC_WORD.
REQ-015 sync_err  output  1  one-cycle strobe on missed sync word.

Function
REQ-016 LFSR SHALL be 16-bit Fibonacci, x^16+x^14+x^13+x^11+1: on step, lfsr <= {lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5], lfsr[15:1]}.
REQ-017 Keystream bit SHALL be lfsr[0] before the step; LFSR SHALL step exactly once per accepted ct_valid cycle, in every state except IDLE.
REQ-018 On accepted bit: pt_bit <= ct_bit ^ lfsr[0], pt_valid <= 1 on the next edge (latency 1 cycle); otherwise pt_valid <= 0, pt_bit holds.
REQ-019 key_load SHALL load key_seed (or SEED_DEFAULT if key_seed==0), clear shift register and bit counter, enter HUNT; key_load wins over a simultaneous ct_valid, whose bit is discarded without LFSR step.
REQ-020 States: IDLE (after reset; ct_valid ignored), HUNT, LOCKED; key_load from any state -> HUNT.
REQ-021 HUNT: each decrypted bit shifts into 8-bit register sr <= {sr[6:0], pt}; when new sr == SYNC_WORD -> LOCKED, bit counter = 0, locked <= 1 same edge.
REQ-022 Sync byte itself SHALL NOT produce byte_valid.
REQ-023 LOCKED: every 8th decrypted bit SHALL produce byte_out = last 8 bits (first received = bit 7), byte_valid high exactly one cycle, latency 1 cycle after the 8th accepted bit's edge.
REQ-024 Bit counter SHALL wrap 7 -> 0; gaps in ct_valid SHALL not affect alignment.
REQ-025 byte_out SHALL hold its value until the next byte_valid.

Reset
REQ-026 With rst==0 at an edge: state IDLE, lfsr = SEED_DEFAULT, sr = 0, counters = 0, pt_bit = 0, pt_valid = 0, byte_out = 8'h00, byte_valid = 0, locked = 0, sync_err = 0.
REQ-027 Reset SHALL override key_load and ct_valid in the same cycle; reset mid-byte discards the partial byte.

Configuration
REQ-028 Macro XOR_RX_RESYNC_EN defined: in LOCKED, after FRAME_LEN payload bytes, the next byte SHALL be compared to SYNC_WORD; match -> no byte_valid, byte counter = 0, stay LOCKED; mismatch -> sync_err pulse one cycle, locked <= 0, sr cleared, state HUNT, no byte_valid.
REQ-029 Macro undefined: LOCKED persists until reset or key_load, all bytes emitted, byte counter absent, sync_err tied 0.

Verification
REQ-030 Reset then ct_valid pulses -> pt_valid stays 0, lfsr unchanged (IDLE).
REQ-031 key_load seed 16'h0000 then ciphertext = plaintext XOR keystream from 16'hACE1 -> pt_bit equals plaintext each bit, 1-cycle latency.
REQ-032 Seed 16'h1234, stream A5,3C,C3 encrypted with random ct_valid gaps -> locked rises after 8th bit; byte_valid twice with 8'h3C then 8'hC3.
REQ-033 key_load asserted with ct_valid in the same cycle -> bit dropped, LFSR equals seed next cycle, state HUNT, locked 0.
REQ-034 XOR_RX_RESYNC_EN, FRAME_LEN=2: A5,11,22,A5,33,44,5A -> bytes 11,22,33,44 emitted; on 5A sync_err one pulse, locked 0.
REQ-035 rst low after 4 bits of a locked byte -> all outputs reset values next cycle, no byte_valid.

Source files
------------

// File: rtl/xor_cipher_rx.sv
// Serial XOR-stream decryptor: an LFSR keystream decrypts ct_bit, then bytes are framed on SYNC_WORD.
// Optional XOR_RX_RESYNC_EN re-checks the sync word after every FRAME_LEN payload bytes.
module xor_cipher_rx #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter logic [7:0]  SYNC_WORD    = 8'hA5,
  parameter int          FRAME_LEN    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [15:0] key_seed,
  input  logic        ct_bit,
  input  logic        ct_valid,
  output logic        pt_bit,
  output logic        pt_valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        locked,
  output logic        sync_err
);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_LOCKED} state_t;

  state_t      state_reg;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [15:0] seed_sel;
  logic [7:0]  sr_reg;
  logic [7:0]  sr_next;
  logic [2:0]  bit_cnt_reg;
  logic        pt_next;
  logic        accept;

  generate
    if (FRAME_LEN < 1) begin : g_frame_len_check
      $error("FRAME_LEN must be at least 1");
    end
  endgenerate

  // Fibonacci taps x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_lfsr_shift
      assign lfsr_next[gi] = lfsr_reg[gi+1];
    end
  endgenerate
  assign lfsr_next[15] = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

  // key_load takes priority: a coincident ciphertext bit is dropped.
  assign accept   = ct_valid && !key_load && (state_reg != S_IDLE);
  assign pt_next  = ct_bit ^ lfsr_reg[0];
  assign sr_next  = {sr_reg[6:0], pt_next};
  assign seed_sel = (key_seed == 16'h0000) ? SEED_DEFAULT : key_seed;

`ifdef XOR_RX_RESYNC_EN
  localparam int BCW = $clog2(FRAME_LEN + 1);
  localparam logic [BCW-1:0] FRAME_LAST = BCW'(FRAME_LEN);

  logic [BCW-1:0] byte_cnt_reg;
  logic           sync_err_reg;

  assign sync_err = sync_err_reg;
`else
  assign sync_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      lfsr_reg     <= SEED_DEFAULT;
      sr_reg       <= 8'h00;
      bit_cnt_reg  <= 3'd0;
      pt_bit       <= 1'b0;
      pt_valid     <= 1'b0;
      byte_out     <= 8'h00;
      byte_valid   <= 1'b0;
      locked       <= 1'b0;
`ifdef XOR_RX_RESYNC_EN
      byte_cnt_reg <= '0;
      sync_err_reg <= 1'b0;
`endif
    end else begin
      pt_valid   <= 1'b0;
      byte_valid <= 1'b0;
`ifdef XOR_RX_RESYNC_EN
      sync_err_reg <= 1'b0;
`endif
      if (key_load) begin
        state_reg    <= S_HUNT;
        lfsr_reg     <= seed_sel;
        sr_reg       <= 8'h00;
        bit_cnt_reg  <= 3'd0;
        locked       <= 1'b0;
`ifdef XOR_RX_RESYNC_EN
        byte_cnt_reg <= '0;
`endif
      end else if (accept) begin
        lfsr_reg <= lfsr_next;
        pt_bit   <= pt_next;
        pt_valid <= 1'b1;
        sr_reg   <= sr_next;
        case (state_reg)
          S_HUNT: begin
            if (sr_next == SYNC_WORD) begin
              state_reg    <= S_LOCKED;
              locked       <= 1'b1;
              bit_cnt_reg  <= 3'd0;
`ifdef XOR_RX_RESYNC_EN
              byte_cnt_reg <= '0;
`endif
            end
          end
          S_LOCKED: begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
`ifdef XOR_RX_RESYNC_EN
              // The byte after a full frame is the expected sync word, never payload.
              if (byte_cnt_reg == FRAME_LAST) begin
                if (sr_next == SYNC_WORD) begin
                  byte_cnt_reg <= '0;
                end else begin
                  sync_err_reg <= 1'b1;
                  locked       <= 1'b0;
                  sr_reg       <= 8'h00;
                  state_reg    <= S_HUNT;
                end
              end else begin
                byte_out     <= sr_next;
                byte_valid   <= 1'b1;
                byte_cnt_reg <= byte_cnt_reg + BCW'(1);
              end
`else
              byte_out   <= sr_next;
              byte_valid <= 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xor_cipher_rx.sv
// Randomized bench for xor_cipher_rx: a bit-level reference model is compared every cycle,
// plus literal checks of keystream, locking, byte framing, key_load and reset behaviour.
module tb_xor_cipher_rx;
  localparam int FL = 2;
  localparam logic [15:0] DEF_SEED = 16'hACE1;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_load = 1'b0;
  logic [15:0] key_seed = 16'h0000;
  logic        ct_bit = 1'b0;
  logic        ct_valid = 1'b0;
  logic        pt_bit, pt_valid, byte_valid, locked, sync_err;
  logic [7:0]  byte_out;

  xor_cipher_rx #(.SEED_DEFAULT(DEF_SEED), .SYNC_WORD(SYNC), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_seed(key_seed),
    .ct_bit(ct_bit), .ct_valid(ct_valid), .pt_bit(pt_bit), .pt_valid(pt_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ks_adv(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Reference model: mode 0 idle, 1 hunting, 2 aligned; counts kept as plain integers.
  int          m_mode;
  logic [15:0] m_ks;
  logic [7:0]  m_hist;
  int          m_bits_since_lock;
  int          m_payload;
  logic        e_pt_bit, e_pt_valid, e_byte_valid, e_locked, e_sync_err;
  logic [7:0]  e_byte_out;

  task automatic model(input logic r, input logic kl, input logic [15:0] sd,
                       input logic v, input logic b);
    logic p;
    if (!r) begin
      m_mode = 0; m_ks = DEF_SEED; m_hist = 8'h00; m_bits_since_lock = 0; m_payload = 0;
      e_pt_bit = 1'b0; e_pt_valid = 1'b0; e_byte_out = 8'h00; e_byte_valid = 1'b0;
      e_locked = 1'b0; e_sync_err = 1'b0;
    end else begin
      e_pt_valid = 1'b0; e_byte_valid = 1'b0; e_sync_err = 1'b0;
      if (kl) begin
        m_ks = (sd == 16'h0000) ? DEF_SEED : sd;
        m_mode = 1; m_hist = 8'h00; m_bits_since_lock = 0; m_payload = 0; e_locked = 1'b0;
      end else if (v && m_mode != 0) begin
        p = b ^ m_ks[0];
        m_ks = ks_adv(m_ks);
        e_pt_bit = p; e_pt_valid = 1'b1;
        m_hist = {m_hist[6:0], p};
        if (m_mode == 1) begin
          if (m_hist == SYNC) begin
            m_mode = 2; e_locked = 1'b1; m_bits_since_lock = 0; m_payload = 0;
          end
        end else begin
          m_bits_since_lock++;
          if (m_bits_since_lock % 8 == 0) begin
`ifdef XOR_RX_RESYNC_EN
            if (m_payload == FL) begin
              if (m_hist == SYNC) m_payload = 0;
              else begin
                e_sync_err = 1'b1; e_locked = 1'b0; m_mode = 1; m_hist = 8'h00;
              end
            end else begin
              e_byte_out = m_hist; e_byte_valid = 1'b1; m_payload++;
            end
`else
            e_byte_out = m_hist; e_byte_valid = 1'b1;
`endif
          end
        end
      end
    end
  endtask

  bit         chk_on = 1'b0;
  logic [7:0] got[$];
  int         n_sync_err = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("pt_bit", pt_bit, e_pt_bit);
      check("pt_valid", pt_valid, e_pt_valid);
      check("byte_out", byte_out, e_byte_out);
      check("byte_valid", byte_valid, e_byte_valid);
      check("locked", locked, e_locked);
      check("sync_err", sync_err, e_sync_err);
      if (byte_valid) got.push_back(byte_out);
      if (sync_err) n_sync_err++;
    end
  end

  logic [15:0] enc_ks;

  task automatic cyc(input logic r, input logic kl, input logic [15:0] sd,
                     input logic v, input logic b);
    rst = r; key_load = kl; key_seed = sd; ct_valid = v; ct_bit = b;
    @(posedge clk);
    model(r, kl, sd, v, b);
    #1;
  endtask

  task automatic load(input logic [15:0] sd);
    cyc(1'b1, 1'b1, sd, 1'($urandom), 1'($urandom));
    enc_ks = (sd == 16'h0000) ? DEF_SEED : sd;
  endtask

  task automatic send_bit(input logic b, input int gapmax);
    int gaps;
    gaps = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    for (int i = 0; i < gaps; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'($urandom));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, b ^ enc_ks[0]);
    enc_ks = ks_adv(enc_ks);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gapmax);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gapmax);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'($urandom));
  endtask

  initial begin
    logic [15:0] s;
    logic [23:0] pt_pat;
    logic [7:0]  tmp;
    int          nb;

    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h1111, 1'b1, 1'b1);
    chk_on = 1'b1;

    // Pin the keystream model: 0xACE1 -> 0x5670 -> 0xAB38 -> 0x559C.
    s = ks_adv(ks_adv(ks_adv(DEF_SEED)));
    check("model_ks", s, 16'h559C);

    // IDLE ignores ct_valid and keeps the LFSR still.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'($urandom));
    check("idle_lfsr", dut.lfsr_reg, DEF_SEED);
    check("idle_pt_valid", pt_valid, 1'b0);

    // Zero seed substitutes the default; plaintext recovered with 1-cycle latency.
    load(16'h0000);
    pt_pat = 24'h5A3C_96;
    for (int i = 23; i >= 0; i--) begin
      send_bit(pt_pat[i], 0);
      check("pt_literal", pt_bit, pt_pat[i]);
      check("pt_valid_literal", pt_valid, 1'b1);
    end
    idle(1);

    // Lock on A5 with gaps, then two payload bytes.
    load(16'h1234);
    got.delete();
    tmp = SYNC;
    for (int i = 7; i >= 0; i--) begin
      send_bit(tmp[i], 3);
      check("lock_edge", locked, (i == 0) ? 1'b1 : 1'b0);
    end
    send_byte(8'h3C, 3);
    send_byte(8'hC3, 3);
    idle(2);
    check("nbytes_032", got.size(), 2);
    if (got.size() == 2) begin
      check("byte0_032", got[0], 8'h3C);
      check("byte1_032", got[1], 8'hC3);
    end

    // key_load beats a simultaneous ct_valid.
    cyc(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    enc_ks = 16'h1234;
    check("kl_lfsr", dut.lfsr_reg, 16'h1234);
    check("kl_locked", locked, 1'b0);
    check("kl_pt_valid", pt_valid, 1'b0);

    // Reset in the middle of a locked byte.
    got.delete();
    send_byte(SYNC, 1);
    check("relock", locked, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1);
    cyc(1'b0, 1'b1, 16'h4321, 1'b1, 1'b1);
    check("rst_outs", {pt_bit, pt_valid, byte_out, byte_valid, locked, sync_err}, 13'h0);
    check("rst_lfsr", dut.lfsr_reg, DEF_SEED);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'($urandom));
    check("rst_no_bytes", got.size(), 0);

`ifdef XOR_RX_RESYNC_EN
    load(16'($urandom));
    got.delete();
    nb = n_sync_err;
    send_byte(8'hA5, 2); send_byte(8'h11, 2); send_byte(8'h22, 2);
    send_byte(8'hA5, 2); send_byte(8'h33, 2); send_byte(8'h44, 2);
    send_byte(8'h5A, 2);
    idle(2);
    check("rs_nbytes", got.size(), 4);
    if (got.size() == 4) begin
      check("rs_b0", got[0], 8'h11); check("rs_b1", got[1], 8'h22);
      check("rs_b2", got[2], 8'h33); check("rs_b3", got[3], 8'h44);
    end
    check("rs_sync_err", n_sync_err - nb, 1);
    check("rs_locked", locked, 1'b0);
`else
    load(16'hBEEF);
    got.delete();
    send_byte(SYNC, 1);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1);
    idle(2);
    check("long_nbytes", got.size(), 20);
`endif

    // Randomized rounds: noise, sync, frames, occasional wrong sync word.
    for (int r = 0; r < 8; r++) begin
      s = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      load(s);
      nb = int'($urandom_range(0, 12));
      for (int i = 0; i < nb; i++) send_bit(1'($urandom), 2);
      send_byte(SYNC, 2);
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < FL; i++) send_byte(8'($urandom), 2);
        send_byte(($urandom_range(0, 2) == 0) ? 8'($urandom) : SYNC, 2);
      end
      idle(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
